// File: rtl/axi4_rd_responder.sv
// AXI4 read responder backed by an on-chip line memory preloaded through a backdoor port.
// Optional macro AXI4_RD_RESPONDER_DECERR_EN: out-of-range start addresses return DECERR beats.
module axi4_rd_responder #(
    parameter int ID_W          = 16,
    parameter int DATA_W        = 512,
    parameter int MEM_LOG_DEPTH = 10,
    parameter int AR_LOG_DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_W-1:0]          ddr_arid,
    input  logic [63:0]              ddr_araddr,
    input  logic [7:0]               ddr_arlen,
    input  logic [2:0]               ddr_arsize,
    input  logic                     ddr_arvalid,
    output logic                     ddr_arready,
    output logic [ID_W-1:0]          ddr_rid,
    output logic [DATA_W-1:0]        ddr_rdata,
    output logic [1:0]               ddr_rresp,
    output logic                     ddr_rlast,
    output logic                     ddr_rvalid,
    input  logic                     ddr_rready,
    input  logic                     bd_wr_en,
    input  logic [MEM_LOG_DEPTH-1:0] bd_wr_idx,
    input  logic [DATA_W-1:0]        bd_wr_data
);
    localparam int AQ_DEPTH  = 1 << AR_LOG_DEPTH;
    localparam int MEM_DEPTH = 1 << MEM_LOG_DEPTH;

    typedef struct packed {
        logic [ID_W-1:0]          id;
        logic [MEM_LOG_DEPTH-1:0] idx;
        logic [7:0]               len;
        logic                     err;
    } ar_req_t;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [DATA_W-1:0]        r_mem [MEM_DEPTH];
    ar_req_t                  r_aq [AQ_DEPTH];
    logic [AR_LOG_DEPTH-1:0]  r_aq_wp, r_aq_rp;
    logic [AR_LOG_DEPTH:0]    r_aq_cnt;
    logic                     r_rst_done;
    state_t                   r_state, w_state_nxt;
    logic [ID_W-1:0]          r_b_id;
    logic [MEM_LOG_DEPTH-1:0] r_b_idx;
    logic [7:0]               r_b_left;
    logic                     r_b_err;
    logic [ID_W-1:0]          r_sk_id   [2];
    logic [DATA_W-1:0]        r_sk_data [2];
    logic [1:0]               r_sk_resp [2];
    logic                     r_sk_last [2];
    logic                     r_sk_wp, r_sk_rp;
    logic [1:0]               r_sk_cnt;

    ar_req_t w_ar_req, w_aq_head;
    logic    w_aq_full, w_aq_empty, w_ar_push, w_aq_pop;
    logic    w_issue, w_r_pop, w_credit, w_ar_err, w_unused;

`ifdef AXI4_RD_RESPONDER_DECERR_EN
    assign w_ar_err = |ddr_araddr[63:MEM_LOG_DEPTH+6];
`else
    assign w_ar_err = 1'b0;
`endif
    // arsize is always treated as full-width; low byte offset never selects a sub-line
    assign w_unused = ^{ddr_arsize, ddr_araddr[5:0], ddr_araddr[63:MEM_LOG_DEPTH+6]};

    assign w_aq_full   = (r_aq_cnt == (AR_LOG_DEPTH+1)'(AQ_DEPTH));
    assign w_aq_empty  = (r_aq_cnt == '0);
    assign ddr_arready = r_rst_done && !w_aq_full;
    assign w_ar_push   = ddr_arvalid && ddr_arready;
    assign w_ar_req    = {ddr_arid, ddr_araddr[MEM_LOG_DEPTH+5:6], ddr_arlen, w_ar_err};
    assign w_aq_head   = r_aq[r_aq_rp];

    always_ff @(posedge clk) begin
        if (bd_wr_en) r_mem[bd_wr_idx] <= bd_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_aq_wp    <= '0;
            r_aq_rp    <= '0;
            r_aq_cnt   <= '0;
            for (int i = 0; i < AQ_DEPTH; i++) r_aq[i] <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_ar_push) begin
                r_aq[r_aq_wp] <= w_ar_req;
                r_aq_wp       <= r_aq_wp + 1'b1;
            end
            if (w_aq_pop) r_aq_rp <= r_aq_rp + 1'b1;
            r_aq_cnt <= r_aq_cnt + (AR_LOG_DEPTH+1)'(w_ar_push) - (AR_LOG_DEPTH+1)'(w_aq_pop);
        end
    end

    // A beat leaving on R this cycle frees its skid slot for the read issued now
    assign w_r_pop  = ddr_rvalid && ddr_rready;
    assign w_credit = (r_sk_cnt - 2'(w_r_pop)) < 2'd2;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_aq_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_aq_empty) begin
                    w_aq_pop    = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_b_left == 8'd0) begin
                        if (!w_aq_empty) w_aq_pop = 1'b1;
                        else             w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_b_id   <= '0;
            r_b_idx  <= '0;
            r_b_left <= '0;
            r_b_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aq_pop) begin
                r_b_id   <= w_aq_head.id;
                r_b_idx  <= w_aq_head.idx;
                r_b_left <= w_aq_head.len;
                r_b_err  <= w_aq_head.err;
            end else if (w_issue) begin
                r_b_idx  <= r_b_idx + 1'b1;
                r_b_left <= r_b_left - 1'b1;
            end
        end
    end

    // Memory read lands directly in the skid slot, so read-before-write gives old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sk_wp  <= 1'b0;
            r_sk_rp  <= 1'b0;
            r_sk_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_sk_id[i]   <= '0;
                r_sk_data[i] <= '0;
                r_sk_resp[i] <= 2'b00;
                r_sk_last[i] <= 1'b0;
            end
        end else begin
            if (w_issue) begin
                r_sk_id[r_sk_wp]   <= r_b_id;
                r_sk_data[r_sk_wp] <= r_b_err ? '0 : r_mem[r_b_idx];
                r_sk_resp[r_sk_wp] <= r_b_err ? 2'b11 : 2'b00;
                r_sk_last[r_sk_wp] <= (r_b_left == 8'd0);
                r_sk_wp            <= ~r_sk_wp;
            end
            if (w_r_pop) r_sk_rp <= ~r_sk_rp;
            r_sk_cnt <= r_sk_cnt + 2'(w_issue) - 2'(w_r_pop);
        end
    end

    assign ddr_rvalid = (r_sk_cnt != 2'd0);
    assign ddr_rid    = r_sk_id[r_sk_rp];
    assign ddr_rdata  = r_sk_data[r_sk_rp];
    assign ddr_rresp  = r_sk_resp[r_sk_rp];
    assign ddr_rlast  = r_sk_last[r_sk_rp];

endmodule
